filt_cici_interp: RTL and testbench
===================================

Name: filt_cici_interp

Overview:
- Multi-stage CIC (cascaded integrator-comb) interpolation filter, up-sampling a low-rate signed input by an integer factor R.
- Sits between a low-rate sample source and a high-rate datapath. It is clocked only by the high-rate clock.
- The input rate is derived internally by a modulo-R phase counter; the block issues a strobe when it captures an input sample.
- Structure: N comb stages at the input rate, zero-stuffing up-sampler, N integrator stages at the output rate.

Parameters:
- gp_interpolation_factor, 8: interpolation ratio R (>=2).
- gp_order, 3: number of comb stages and number of integrator stages, N (>=1).
- gp_diff_delay, 1: comb differential delay M (1 or 2).
- gp_phase, 0: counter value (0..R-1) on which the input sample is captured.
- gp_inp_width, 16: input width, two's complement.
- gp_oup_width, 22: output width, two's complement. The default equals full precision Bout = gp_inp_width + clog2((R*M)^N / R).

Ports:
- i_clk, input, 1: output-rate clock. Single clock domain; all logic uses the rising edge.
- i_rst, input, 1: synchronous reset, active high.
- i_ena, input, 1: global enable. When low, all state holds.
- i_data, input, gp_inp_width: signed low-rate sample. It need only be valid on the cycle o_strobe is high.
- o_strobe, output, 1: one-cycle pulse marking the cycle on which i_data is captured. This is the input-rate request.
- o_data, output, gp_oup_width: signed high-rate filtered output, one sample every enabled cycle.

Behaviour:
- Reset (i_rst high at a clock edge):
  - Phase counter, input register, all comb delay elements, the up-sampler flag and all integrators clear to 0.
  - o_data = 0 and o_strobe = 0 from the following cycle.
  - Reset overrides i_ena. Reset mid-operation discards all state, and the counter restarts at 0.
- Enable:
  - With i_ena low, no register changes, including the counter, and o_data holds.
  - With i_ena high, the block advances one output sample per clock.
- Phase counter:
  - Counts 0..R-1 and wraps to 0.
  - Strobe condition: counter == gp_phase, which occurs once every R enabled cycles.
  - o_strobe is asserted combinationally during that cycle, gated by i_ena.
- Capture: on the strobe edge, the input register is loaded with i_data.
- Internal width: W = gp_inp_width + N*clog2(R*M) for all comb and integrator registers.
  - The input is sign-extended to W.
  - Arithmetic is modulo 2^W; integrator wrap-around is intentional and cancels exactly.
- Comb chain:
  - Stage k output is stage k input minus that same input from M strobes earlier.
  - The M-deep delay lines advance only on strobe edges.
  - The chain is combinational from the input register and the delay lines.
- Up-sampler:
  - Drives the comb output on the cycle immediately after the strobe edge.
  - Drives zero on the other R-1 cycles of each frame.
- Integrators: N registered stages.
  - integ1 <= integ1 + upsampler output.
  - integk <= integk + integ(k-1).
  - All stages update on every enabled edge.
- Latency:
  - A sample captured at edge t first affects integN at edge t+1+N.
  - o_data = integN, so the effect is visible after that edge.
- Gain: DC gain = (R*M)^N / R, which is 64 at the defaults.
- Output formatting:
  - If gp_oup_width >= Bout, o_data is integN sign-extended.
  - Otherwise, o_data is the gp_oup_width MSBs of the Bout-bit result, truncated (floor); no rounding and no saturation.
- Input sample that changes between strobes: ignored. Only the value present at the strobe edge is used.

Test Plan:
- Reset check: assert i_rst for 3 cycles with i_ena high and i_data = 1234 -> o_data = 0 and counter = 0 throughout; o_strobe first asserts on the cycle when the counter equals gp_phase after release.
- Impulse response (defaults): i_data = 1 on the first strobe, then 0 -> o_data sequence after N+1 cycles: 1,3,6,10,15,21,28,36,…; the sequence is symmetric, sums to 512, spans 22 samples, then returns to 0.
- Step / DC gain (defaults): i_data = 1 held -> o_data settles to 64 on every cycle; i_data = -32768 held -> o_data settles to -2097152 with no overflow.
- Full-scale alternating input (+32767 / -32768 on each strobe) for 1000 strobes -> o_data bit-exact against a full-precision CIC reference model; no divergence despite integrator wrap.
- Enable gating: drop i_ena for 5 cycles mid-stream -> o_data and the counter freeze; after re-enable, the sequence resumes exactly where it stopped (equivalent to the ungated stream with a time shift).
- Parameter variants: R=4, N=2, M=2, gp_phase=3, gp_oup_width=12 (< Bout = 20) -> capture occurs on counter 3; o_data equals the reference output floor-truncated to 12 MSBs.

Source files
------------

// File: rtl/filt_cici_interp.sv
// CIC interpolator: N combs at the input rate, zero-stuffing by R, N integrators at the output rate.
// The input rate is derived from a modulo-R phase counter; o_strobe requests the next low-rate sample.
module filt_cici_interp #(
    parameter int gp_interpolation_factor = 8,
    parameter int gp_order                = 3,
    parameter int gp_diff_delay           = 1,
    parameter int gp_phase                = 0,
    parameter int gp_inp_width            = 16,
    parameter int gp_oup_width            = 22
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_ena,
    input  logic [gp_inp_width-1:0] i_data,
    output logic                    o_strobe,
    output logic [gp_oup_width-1:0] o_data
);

    function automatic int f_growth(input int unsigned r, input int unsigned m, input int unsigned n);
        longint unsigned g;
        g = 1;
        for (int unsigned i = 0; i < n; i++) begin
            g = g * longint'(r * m);
        end
        g = g / longint'(r);
        return int'($clog2(g));
    endfunction

    localparam int LP_R    = gp_interpolation_factor;
    localparam int LP_N    = gp_order;
    localparam int LP_M    = gp_diff_delay;
    localparam int LP_W    = gp_inp_width + LP_N * $clog2(LP_R * LP_M);
    localparam int LP_BOUT = gp_inp_width + f_growth(LP_R, LP_M, LP_N);
    localparam int LP_CW   = $clog2(LP_R);

    logic [LP_CW-1:0]        r_cnt;
    logic                    r_up;
    logic signed [LP_W-1:0]  r_in;
    logic signed [LP_W-1:0]  r_ups;
    logic signed [LP_W-1:0]  r_dly   [0:LP_N-1][0:LP_M-1];
    logic signed [LP_W-1:0]  r_integ [0:LP_N-1];
    logic signed [LP_W-1:0]  w_c     [0:LP_N];
    logic signed [LP_BOUT-1:0] w_full;
    logic                    w_strobe;
    logic                    w_unused;

    assign w_strobe = i_ena & ~i_rst & (r_cnt == LP_CW'(gp_phase));
    assign o_strobe = w_strobe;

    // Comb chain is combinational; delay lines hold the stage inputs of the last M strobes.
    assign w_c[0] = r_in;
    genvar gk;
    for (gk = 0; gk < LP_N; gk++) begin : g_comb
        assign w_c[gk+1] = w_c[gk] - r_dly[gk][LP_M-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_in  <= '0;
            r_up  <= 1'b0;
            r_ups <= '0;
            for (int unsigned k = 0; k < LP_N; k++) begin
                r_integ[k] <= '0;
                for (int unsigned m = 0; m < LP_M; m++) begin
                    r_dly[k][m] <= '0;
                end
            end
        end else if (i_ena) begin
            if (r_cnt == LP_CW'(LP_R - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + LP_CW'(1);
            end
            r_up  <= w_strobe;
            r_ups <= r_up ? w_c[LP_N] : '0;
            if (w_strobe) begin
                r_in <= LP_W'($signed(i_data));
                for (int unsigned k = 0; k < LP_N; k++) begin
                    r_dly[k][0] <= w_c[k];
                    for (int unsigned m = 1; m < LP_M; m++) begin
                        r_dly[k][m] <= r_dly[k][m-1];
                    end
                end
            end
            r_integ[0] <= r_integ[0] + r_ups;
            for (int unsigned k = 1; k < LP_N; k++) begin
                r_integ[k] <= r_integ[k] + r_integ[k-1];
            end
        end
    end

    // Integrator wrap is harmless: only the low Bout bits carry the result.
    assign w_full   = r_integ[LP_N-1][LP_BOUT-1:0];
    assign w_unused = ^r_integ[LP_N-1];

    if (gp_oup_width >= LP_BOUT) begin : g_ext
        assign o_data = gp_oup_width'(w_full);
    end else begin : g_trunc
        assign o_data = w_full[LP_BOUT-1 -: gp_oup_width];
    end

endmodule

// File: tb/tb_filt_cici_interp.sv
// Scoreboard bench for filt_cici_interp: default instance plus an R=4/N=2/M=2/phase=3/12-bit variant,
// both checked against a convolution reference built from the N-fold boxcar impulse response.
module tb_filt_cici_interp;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ena = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_strobe_a;
    logic [21:0] o_data_a;
    logic        o_strobe_b;
    logic [11:0] o_data_b;

    always #5 clk = ~clk;

    filt_cici_interp dut_a (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_ena    (i_ena),
        .i_data   (i_data),
        .o_strobe (o_strobe_a),
        .o_data   (o_data_a)
    );

    filt_cici_interp #(
        .gp_interpolation_factor (4),
        .gp_order                (2),
        .gp_diff_delay           (2),
        .gp_phase                (3),
        .gp_inp_width            (16),
        .gp_oup_width            (12)
    ) dut_b (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_ena    (i_ena),
        .i_data   (i_data),
        .o_strobe (o_strobe_b),
        .o_data   (o_data_b)
    );

    typedef struct {
        int     cyc;
        bit     s_a;
        longint d_a;
        bit     s_b;
        longint d_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int P_R[2]    = '{8, 4};
    int P_N[2]    = '{3, 2};
    int P_M[2]    = '{1, 2};
    int P_PH[2]   = '{0, 3};
    int P_OW[2]   = '{22, 12};
    int P_BOUT[2] = '{22, 20};

    longint m_h[2][0:63];
    int     m_hl[2];
    int     m_cnt[2];
    longint m_e[2];
    int     m_n[2];
    longint m_rt[2][0:7];
    longint m_rx[2][0:7];
    longint m_last[2];

    task automatic build_h(input int k);
        longint tmp[0:63];
        longint t;
        int     b;
        m_hl[k] = 1;
        m_h[k][0] = 1;
        b = P_R[k] * P_M[k];
        for (int s = 0; s < P_N[k]; s++) begin
            for (int i = 0; i < m_hl[k] + b - 1; i++) begin
                t = 0;
                for (int j = 0; j < b; j++) begin
                    if (i - j >= 0 && i - j < m_hl[k]) t += m_h[k][i-j];
                end
                tmp[i] = t;
            end
            m_hl[k] = m_hl[k] + b - 1;
            for (int i = 0; i < m_hl[k]; i++) m_h[k][i] = tmp[i];
        end
    endtask

    // Output after the edge ending this cycle: sum of x_s * h[e - t_s - 1 - N] over captured samples.
    task automatic model_step(input int k, input bit rst, input bit ena, input longint x,
                              output bit s, output longint d);
        longint y;
        int     idx;
        int     sh;
        if (rst) begin
            m_cnt[k] = 0; m_e[k] = 0; m_n[k] = 0; m_last[k] = 0;
            s = 1'b0; d = 0;
        end else if (!ena) begin
            s = 1'b0; d = m_last[k];
        end else begin
            s = (m_cnt[k] == P_PH[k]);
            m_e[k] = m_e[k] + 1;
            if (s) begin
                m_rt[k][m_n[k] % 8] = m_e[k];
                m_rx[k][m_n[k] % 8] = x;
                m_n[k] = m_n[k] + 1;
            end
            m_cnt[k] = (m_cnt[k] + 1) % P_R[k];
            y = 0;
            for (int j = 0; j < 8; j++) begin
                if (j < m_n[k]) begin
                    idx = int'(m_e[k] - m_rt[k][j]) - 1 - P_N[k];
                    if (idx >= 0 && idx < m_hl[k]) y += m_rx[k][j] * m_h[k][idx];
                end
            end
            sh = 64 - P_BOUT[k];
            y = (y <<< sh) >>> sh;
            if (P_OW[k] < P_BOUT[k]) y = y >>> (P_BOUT[k] - P_OW[k]);
            d = y;
            m_last[k] = d;
        end
    endtask

    task automatic drive(input bit rst, input bit ena, input longint data);
        exp_t e;
        @(posedge clk);
        #2;
        i_rst  = rst;
        i_ena  = ena;
        i_data = 16'(data);
        model_step(0, rst, ena, longint'($signed(i_data)), e.s_a, e.d_a);
        model_step(1, rst, ena, longint'($signed(i_data)), e.s_b, e.d_b);
        e.cyc = cyc;
        cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int c, input longint got, input longint want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_err = n_err + 1;
            $display("FAIL %s cycle %0d: got %0d, want %0d", name, c, got, want);
        end
    endtask

    initial begin : monitor
        exp_t cur;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check("strobe_a", cur.cyc, longint'(o_strobe_a), longint'(cur.s_a));
                check("strobe_b", cur.cyc, longint'(o_strobe_b), longint'(cur.s_b));
                @(posedge clk);
                #1;
                check("data_a", cur.cyc, longint'($signed(o_data_a)), cur.d_a);
                check("data_b", cur.cyc, longint'($signed(o_data_b)), cur.d_b);
            end
        end
    end

    initial begin : stim
        build_h(0);
        build_h(1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1234);
        // impulse: value 1 spans the first strobe of both instances
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 0);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1);
        for (int i = 0; i < 48; i++) drive(1'b0, 1'b1, -32768);
        // full-scale alternation: every 8-cycle window holds exactly one default-instance strobe
        for (int i = 0; i < 8000; i++) drive(1'b0, 1'b1, ((i >> 3) & 1) != 0 ? -32768 : 32767);
        for (int i = 0; i < 60; i++) begin
            if (i >= 20 && i < 25) drive(1'b0, 1'b0, 999);
            else drive(1'b0, 1'b1, longint'(i * 37 - 500));
        end
        drive(1'b1, 1'b1, 4321);
        drive(1'b1, 1'b0, 4321);
        for (int i = 0; i < 120; i++) begin
            drive(1'b0, $urandom_range(0, 7) != 0, longint'($urandom_range(0, 65535)));
        end
        repeat (3) @(posedge clk);
        #3;
        n_cmp = n_cmp + 1;
        if (exp_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
